// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter: round-robin grant held for a whole CYC tenure,
// plus a watchdog that ends a stalled access with a one-cycle ERR.
module wb_arbiter_2m #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned TO_W    = 8
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_sel_i,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   output logic [31:0] m0_dat_o,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_sel_i,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic [31:0] m1_dat_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   output logic [3:0]  s_sel_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   input  logic        s_ack_i,
   input  logic [31:0] s_dat_i,
   output logic [1:0]  grant_o,
   output logic        timeout_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

   localparam bit             WD_EN   = (TIMEOUT != 0);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t          state_q, state_d;
   logic            last_q, last_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            err_q, err_d;

   logic [1:0]        m_cyc, m_stb, m_we;
   logic [1:0][3:0]   m_sel;
   logic [1:0][31:0]  m_adr, m_dat;
   logic              owned, own;

   assign m_cyc = {m1_cyc_i, m0_cyc_i};
   assign m_stb = {m1_stb_i, m0_stb_i};
   assign m_we  = {m1_we_i,  m0_we_i};
   assign m_sel = {m1_sel_i, m0_sel_i};
   assign m_adr = {m1_adr_i, m0_adr_i};
   assign m_dat = {m1_dat_i, m0_dat_i};

   assign owned = (state_q != IDLE);
   assign own   = (state_q == OWN1);

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // last tracks the most recent winner so a tie goes to the other master
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               state_d = last_q ? OWN0 : OWN1;
               last_d  = ~last_q;
            end else if (m0_cyc_i) begin
               state_d = OWN0;
               last_d  = 1'b0;
            end else if (m1_cyc_i) begin
               state_d = OWN1;
               last_d  = 1'b1;
            end
         end
         OWN0:    if (!m0_cyc_i) state_d = IDLE;
         OWN1:    if (!m1_cyc_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // counter stays at zero through the error cycle, so a master that keeps
   // STB up after ERR starts a fresh timeout window
   always_comb begin
      cnt_d = '0;
      err_d = 1'b0;
      if (WD_EN && owned && m_cyc[own] && m_stb[own] && !s_ack_i && !err_q) begin
         if (cnt_q == TO_LAST) err_d = 1'b1;
         else                  cnt_d = cnt_q + TO_W'(1);
      end
   end

   assign s_cyc_o = owned & m_cyc[own];
   assign s_stb_o = owned & m_stb[own] & ~err_q;
   assign s_we_o  = owned & m_we[own];
   assign s_sel_o = owned ? m_sel[own] : '0;
   assign s_adr_o = owned ? m_adr[own] : '0;
   assign s_dat_o = owned ? m_dat[own] : '0;

   assign grant_o   = {state_q == OWN1, state_q == OWN0};
   assign timeout_o = err_q;

   assign m0_ack_o = grant_o[0] & s_ack_i & ~err_q;
   assign m1_ack_o = grant_o[1] & s_ack_i & ~err_q;
   assign m0_err_o = grant_o[0] & err_q;
   assign m1_err_o = grant_o[1] & err_q;
   assign m0_dat_o = grant_o[0] ? s_dat_i : '0;
   assign m1_dat_o = grant_o[1] ? s_dat_i : '0;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: directed scenarios then random traffic, all outputs
// compared every cycle against an owner/stall-count model of the arbiter.
module tb_wb_arbiter_2m;

   localparam int TO = 16;

   logic clk;
   logic rst;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  cyc, stb, we;
   logic [3:0]  sel  [2];
   logic [31:0] adr  [2];
   logic [31:0] wdat [2];
   logic        ack;
   logic [31:0] sdat;

   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic [31:0] m0_dat, m1_dat;
   logic        s_cyc, s_stb, s_we, tmo;
   logic [3:0]  s_sel;
   logic [31:0] s_adr, s_dat;
   logic [1:0]  grant;

   wb_arbiter_2m #(.TIMEOUT(TO), .TO_W(8)) dut (
      .wb_clk_i (clk),     .wb_rst_i (rst),
      .m0_cyc_i (cyc[0]),  .m0_stb_i (stb[0]), .m0_we_i (we[0]),
      .m0_sel_i (sel[0]),  .m0_adr_i (adr[0]), .m0_dat_i (wdat[0]),
      .m0_ack_o (m0_ack),  .m0_err_o (m0_err), .m0_dat_o (m0_dat),
      .m1_cyc_i (cyc[1]),  .m1_stb_i (stb[1]), .m1_we_i (we[1]),
      .m1_sel_i (sel[1]),  .m1_adr_i (adr[1]), .m1_dat_i (wdat[1]),
      .m1_ack_o (m1_ack),  .m1_err_o (m1_err), .m1_dat_o (m1_dat),
      .s_cyc_o  (s_cyc),   .s_stb_o  (s_stb),  .s_we_o   (s_we),
      .s_sel_o  (s_sel),   .s_adr_o  (s_adr),  .s_dat_o  (s_dat),
      .s_ack_i  (ack),     .s_dat_i  (sdat),
      .grant_o  (grant),   .timeout_o(tmo)
   );

   int npass = 0;
   int nchk  = 0;

   // model: owner (-1 idle), last winner, consecutive stalled strobe edges
   int mo_owner, mo_last, mo_stall;
   bit mo_err;

   logic [31:0] wv [3];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic model_reset();
      mo_owner = -1;
      mo_last  = 1;
      mo_stall = 0;
      mo_err   = 1'b0;
   endtask

   task automatic model_edge();
      int  nxt;
      bit  err_now;
      if (rst) begin
         model_reset();
         return;
      end
      err_now = mo_err;
      mo_err  = 1'b0;
      nxt     = mo_owner;
      if (mo_owner < 0) begin
         if (cyc[0] && cyc[1]) nxt = 1 - mo_last;
         else if (cyc[0])      nxt = 0;
         else if (cyc[1])      nxt = 1;
         if (nxt >= 0) mo_last = nxt;
         mo_stall = 0;
      end else if (!cyc[mo_owner]) begin
         nxt      = -1;
         mo_stall = 0;
      end else if (stb[mo_owner] && !ack && !err_now) begin
         mo_stall++;
         if (mo_stall == TO) begin
            mo_err   = 1'b1;
            mo_stall = 0;
         end
      end else begin
         mo_stall = 0;
      end
      mo_owner = nxt;
   endtask

   task automatic check_all(input string tag);
      bit ov;
      int oi;
      ov = (mo_owner >= 0);
      oi = ov ? mo_owner : 0;
      chk({tag, ".grant"}, grant, ov ? (mo_owner == 0 ? 2'b01 : 2'b10) : 2'b00);
      chk({tag, ".s_cyc"}, s_cyc, ov & cyc[oi]);
      chk({tag, ".s_stb"}, s_stb, ov & stb[oi] & !mo_err);
      chk({tag, ".s_we"},  s_we,  ov & we[oi]);
      chk({tag, ".s_sel"}, s_sel, ov ? sel[oi] : 4'h0);
      chk({tag, ".s_adr"}, s_adr, ov ? adr[oi] : 32'h0);
      chk({tag, ".s_dat"}, s_dat, ov ? wdat[oi] : 32'h0);
      chk({tag, ".m0_ack"}, m0_ack, (mo_owner == 0) && ack && !mo_err);
      chk({tag, ".m1_ack"}, m1_ack, (mo_owner == 1) && ack && !mo_err);
      chk({tag, ".m0_err"}, m0_err, (mo_owner == 0) && mo_err);
      chk({tag, ".m1_err"}, m1_err, (mo_owner == 1) && mo_err);
      chk({tag, ".m0_dat"}, m0_dat, (mo_owner == 0) ? sdat : 32'h0);
      chk({tag, ".m1_dat"}, m1_dat, (mo_owner == 1) ? sdat : 32'h0);
      chk({tag, ".tmo"},   tmo,   mo_err);
   endtask

   // inputs are driven just after a falling edge; one call = one clock cycle
   task automatic cycle(input string tag);
      #1 check_all(tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      cyc = '0; stb = '0; we = '0; ack = 1'b0; sdat = '0;
      for (int i = 0; i < 2; i++) begin
         sel[i] = '0; adr[i] = '0; wdat[i] = '0;
      end
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      model_reset();
      cycle("rst");
      rst = 1'b0;
   endtask

   initial begin
      wv[0] = 32'h1111_0001; wv[1] = 32'h2222_0002; wv[2] = 32'h3333_0003;
      idle_inputs();
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      cycle("por");
      rst = 1'b0;

      // single m0 read, slave answers two cycles after strobe
      cyc[0] = 1; stb[0] = 1; we[0] = 0; sel[0] = 4'hF; adr[0] = 32'h4100_0000;
      cycle("rd_idle");
      cycle("rd_stb0");
      cycle("rd_stb1");
      ack = 1; sdat = 32'hDEAD_BEEF;
      #1;
      chk("rd.ack", m0_ack, 1'b1);
      chk("rd.dat", m0_dat, 32'hDEAD_BEEF);
      chk("rd.grant", grant, 2'b01);
      chk("rd.m1_ack", m1_ack, 1'b0);
      cycle("rd_ack");
      idle_inputs();
      cycle("rd_end0");
      cycle("rd_end1");

      // simultaneous requests alternate, one dead cycle between tenures
      do_reset();
      cyc = 2'b11; stb = 2'b11; adr[1] = 32'h4100_0008;
      cycle("tie_idle");
      #1 chk("tie.first", grant, 2'b01);
      cycle("tie_own0");
      cyc[0] = 0; stb[0] = 0;
      cycle("tie_drop0");
      #1 chk("tie.dead", grant, 2'b00);
      cycle("tie_dead");
      #1 chk("tie.second", grant, 2'b10);
      cycle("tie_own1");
      cyc[1] = 0; stb[1] = 0;
      cycle("tie_drop1");
      cycle("tie_dead2");
      cyc = 2'b11; stb = 2'b11;
      cycle("tie2_idle");
      #1 chk("tie.alt", grant, 2'b01);
      cycle("tie2_own0");
      idle_inputs();
      cycle("tie2_end0");
      cycle("tie2_end1");

      // m1 burst of three writes while m0 waits
      cyc[1] = 1; stb[1] = 1; we[1] = 1; sel[1] = 4'b0011; adr[1] = 32'h4100_0004;
      wdat[1] = wv[0];
      cycle("wr_idle");
      cyc[0] = 1; stb[0] = 1; adr[0] = 32'h4100_0010;
      for (int k = 0; k < 3; k++) begin
         wdat[1] = wv[k]; ack = 1;
         #1;
         chk("wr.grant", grant, 2'b10);
         chk("wr.sel", s_sel, 4'b0011);
         chk("wr.adr", s_adr, 32'h4100_0004);
         chk("wr.dat", s_dat, wv[k]);
         chk("wr.m1_ack", m1_ack, 1'b1);
         chk("wr.m0_ack", m0_ack, 1'b0);
         cycle("wr_beat");
      end
      ack = 0; cyc[1] = 0; stb[1] = 0;
      #1 chk("wr.hold", grant, 2'b10);
      cycle("wr_drop");
      #1 chk("wr.dead", grant, 2'b00);
      cycle("wr_dead");
      #1 chk("wr.m0_turn", grant, 2'b01);
      cycle("wr_m0");
      idle_inputs();
      cycle("wr_end0");
      cycle("wr_end1");

      // slave never acks: err after TO strobe cycles, for exactly one cycle
      cyc[0] = 1; stb[0] = 1; adr[0] = 32'h4100_0020;
      cycle("to_idle");
      for (int k = 0; k < TO; k++) begin
         #1;
         chk("to.no_err", m0_err, 1'b0);
         chk("to.stb", s_stb, 1'b1);
         cycle("to_wait");
      end
      #1;
      chk("to.err", m0_err, 1'b1);
      chk("to.pulse", tmo, 1'b1);
      chk("to.stb_low", s_stb, 1'b0);
      chk("to.no_ack", m0_ack, 1'b0);
      cycle("to_err");
      stb[0] = 0;
      #1;
      chk("to.err_once", m0_err, 1'b0);
      chk("to.pulse_once", tmo, 1'b0);
      cycle("to_after");
      idle_inputs();
      cycle("to_end0");
      cycle("to_end1");

      // ack on the threshold cycle beats the timeout
      cyc[0] = 1; stb[0] = 1; adr[0] = 32'h4100_0030;
      cycle("race_idle");
      for (int k = 0; k < TO - 1; k++) cycle("race_wait");
      ack = 1; sdat = 32'hCAFE_0001;
      #1 chk("race.ack", m0_ack, 1'b1);
      cycle("race_ack");
      ack = 0; stb[0] = 0;
      #1;
      chk("race.no_err", m0_err, 1'b0);
      chk("race.no_tmo", tmo, 1'b0);
      cycle("race_after");
      idle_inputs();
      cycle("race_end0");
      cycle("race_end1");

      // asynchronous reset in the middle of an m1 tenure
      cyc[1] = 1; stb[1] = 1; adr[1] = 32'h4100_0040;
      cycle("ar_idle");
      cyc[0] = 1; stb[0] = 1;
      #1 chk("ar.own1", grant, 2'b10);
      #1 rst = 1'b1;
      #1;
      chk("ar.s_cyc", s_cyc, 1'b0);
      chk("ar.grant", grant, 2'b00);
      model_reset();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      cycle("ar_held");
      rst = 1'b0;
      cycle("ar_rel");
      #1 chk("ar.m0_wins", grant, 2'b01);
      cycle("ar_own0");
      idle_inputs();
      cycle("ar_end0");
      cycle("ar_end1");

      // random traffic, alternating chatty and hanging slave phases
      for (int n = 0; n < 2000; n++) begin
         bit hang;
         hang = ((n / 150) % 2) == 1;
         for (int i = 0; i < 2; i++) begin
            if (cyc[i]) begin
               if ($urandom_range(hang ? 63 : 9, 0) == 0) begin
                  cyc[i] = 1'b0; stb[i] = 1'b0;
               end else begin
                  stb[i] = hang ? 1'b1 : ($urandom_range(3, 0) != 0);
               end
            end else begin
               cyc[i] = ($urandom_range(3, 0) == 0);
               stb[i] = cyc[i] & 1'($urandom_range(1, 0));
            end
            we[i]   = 1'($urandom_range(1, 0));
            sel[i]  = 4'($urandom_range(15, 0));
            adr[i]  = $urandom;
            wdat[i] = $urandom;
         end
         ack  = hang ? ($urandom_range(99, 0) < 2) : 1'($urandom_range(1, 0));
         sdat = $urandom;
         cycle("rnd");
      end

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
- Two-master, one-slave Wishbone arbiter. Lets the management core (m0) and a debug bridge (m1) share the user-area register slaves, such as the debug register bank.
- Round-robin grant, held for a full CYC tenure.
- Bus-timeout watchdog: a slave that never acks produces an error termination instead of hanging the bus.

Parameters:
- TIMEOUT, 255, cycles of STB-high-without-ACK before error termination; 0 disables the watchdog.
- TO_W, 8, timeout counter width; must hold TIMEOUT.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 control
- m0_sel_i  in  4  master 0 byte select
- m0_adr_i  in  32  master 0 address
- m0_dat_i  in  32  master 0 write data
- m0_ack_o  out  1  master 0 acknowledge
- m0_err_o  out  1  master 0 error (timeout)
- m0_dat_o  out  32  master 0 read data
- m1_*  same set as m0_*, for master 1
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave control
- s_sel_o  out  4  slave byte select
- s_adr_o  out  32  slave address
- s_dat_o  out  32  slave write data
- s_ack_i  in  1  slave acknowledge
- s_dat_i  in  32  slave read data
- grant_o  out  2  one-hot current owner; 00 = idle
- timeout_o  out  1  one-cycle pulse on each timeout

Behaviour:
- Reset (async, any time): state=IDLE, last=1 (so m0 wins the first tie), counter=0, err regs=0, grant_o=00, timeout_o=0.
  - All slave and master outputs are 0, because every mux output is gated by grant.
  - Reset mid-tenure drops s_cyc_o immediately; the in-flight access is abandoned.
- State machine: IDLE, OWN0, OWN1.
- IDLE transitions, evaluated at the clock edge:
  - only m0_cyc_i high -> OWN0;
  - only m1_cyc_i high -> OWN1;
  - both high -> the master not equal to last; last is updated to the winner.
- OWNx -> IDLE on the edge where mx_cyc_i is low.
  - Exactly one dead (IDLE) cycle separates tenures.
  - An owner holding CYC keeps the bus indefinitely; no preemption.
- Grant latency: a request first seen at edge N drives s_cyc_o from cycle N+1 (one-cycle registered latency).
- Slave-facing mux, combinational from the registered state:
  - s_cyc_o = owner cyc; s_we_o, s_sel_o, s_adr_o, s_dat_o = owner's inputs.
  - s_stb_o = owner stb AND NOT err_pending.
  - In IDLE all slave outputs are 0.
- Return path:
  - owner ack = s_ack_i; owner dat_o = s_dat_i.
  - Non-owner ack_o, err_o and dat_o are held 0.
  - An s_ack_i arriving in IDLE is ignored.
- Watchdog (TIMEOUT>0):
  - Counter increments each OWNx cycle with owner stb=1 and s_ack_i=0.
  - Counter clears on s_ack_i, on stb=0, and on leaving OWNx.
  - When counter == TIMEOUT-1 and s_ack_i=0: err_pending set and counter cleared.
  - Next cycle: owner err_o=1 and timeout_o=1 for exactly one cycle; s_stb_o forced 0 in that cycle.
  - First STB at edge E with no ack -> err_o high in cycle E+TIMEOUT.
  - If s_ack_i and threshold coincide, the ack wins: no error.
  - ack_o and err_o are never high in the same cycle.
- Master STB after err: the master must drop STB. If it keeps STB high, the counter restarts from 0.
- TIMEOUT=0: counter held 0; err_o and timeout_o never assert.

Test Plan:
- m0 read, address 0x4100_0000; slave acks 2 cycles after s_stb_o with data 0xDEADBEEF -> m0_ack_o=1 with m0_dat_o=0xDEADBEEF; m1_ack_o=0 throughout; grant_o=01.
- m0 and m1 both raise CYC at the same edge after reset -> m0 served first. After m0 drops CYC: one IDLE cycle, then grant_o=10. Next simultaneous request -> m0 again (alternation).
- m1 holds CYC over 3 back-to-back writes (sel=0011, 0x4100_0004); m0 requests meanwhile -> m0 waits, no grant until m1 drops CYC; all 3 writes reach the slave with correct sel and data.
- TIMEOUT=16, slave never acks, m0 STB from edge E -> m0_err_o and timeout_o high exactly in cycle E+16 for one cycle; s_stb_o=0 in that cycle; m0_ack_o never high.
- Slave acks in the same cycle the counter hits TIMEOUT-1 -> ack delivered, no err.
- Assert wb_rst_i mid-transaction during OWN1 -> s_cyc_o and grant_o go to 0 without waiting for a clock edge. After release with both masters requesting -> m0 wins.
